// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: PC control, ROM request/ack, decode handshake.
// master = fetch unit side, slave = PC/ROM/decode side.
interface fetch_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] pc;
    logic             pc_inc;
    logic             pc_load;
    logic [WIDTH-1:0] pc_in;
    logic             rom_req;
    logic [WIDTH-1:0] rom_addr;
    logic             rom_ack;
    logic [WIDTH-1:0] rom_data;
    logic             redirect;
    logic [WIDTH-1:0] redirect_addr;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;

    modport master (
        input  pc, rom_ack, rom_data, redirect, redirect_addr, instr_ready,
        output pc_inc, pc_load, pc_in, rom_req, rom_addr,
        output instr_valid, instr, instr_pc
    );

    modport slave (
        output pc, rom_ack, rom_data, redirect, redirect_addr, instr_ready,
        input  pc_inc, pc_load, pc_in, rom_req, rom_addr,
        input  instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: drives PC inc/load, single-outstanding ROM reads,
// FWFT FIFO of {pc, instr} to decode; redirect reloads PC and flushes.
// Ports: clk, reset (async, active-high), bus (fetch_unit_if.master).
module fetch_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input logic         clk,
    input logic         reset,
    fetch_unit_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] addr_q;
    logic             req_q;

    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;

    logic [WIDTH-1:0] mem_instr [DEPTH];
    logic [WIDTH-1:0] mem_pc    [DEPTH];

    logic             push;
    logic             pop;
    logic             valid;
    logic [CW:0]      occ_after;
    logic             room;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        valid     = (count_q != '0);
        push      = (state_q == REQ) & bus.rom_ack & ~bus.redirect;
        pop       = valid & bus.instr_ready & ~bus.redirect;
        // occupancy after this cycle's push, minus a same-cycle pop
        occ_after = {1'b0, count_q} + (CW+1)'(1) - (CW+1)'(pop);
        room      = occ_after < {1'b0, DEPTH_C};
    end

    always_comb begin
        count_d = count_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (bus.redirect) begin
            count_d = '0;
            wr_d    = '0;
            rd_d    = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
            if (push) wr_d = ptr_inc(wr_q);
            if (pop)  rd_d = ptr_inc(rd_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // storage needs no reset: entries are only read while count != 0
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_q] <= bus.rom_data;
            mem_pc[wr_q]    <= addr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.redirect && count_q < DEPTH_C) begin
                        addr_q  <= bus.pc;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (bus.redirect) begin
                        // an unacked request must still be drained
                        if (bus.rom_ack) begin
                            req_q   <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= FLUSH;
                        end
                    end else if (bus.rom_ack) begin
                        if (room) begin
                            addr_q <= addr_q + 1'b1;
                        end else begin
                            req_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (bus.rom_ack) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.pc_inc      = push;
    assign bus.pc_load     = bus.redirect;
    assign bus.pc_in       = bus.redirect_addr;
    assign bus.rom_req     = req_q;
    assign bus.rom_addr    = addr_q;
    assign bus.instr_valid = valid;
    assign bus.instr       = mem_instr[rd_q];
    assign bus.instr_pc    = mem_pc[rd_q];
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal checks plus a
// queue-based model compared every cycle on the falling edge.
module tb_fetch_unit;
    localparam int W = 16;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] pc = '0;
    logic         rom_ack;
    logic         redirect;
    logic [W-1:0] redirect_addr;
    logic         instr_ready;

    int checks   = 0;
    int failures = 0;

    fetch_unit_if #(.WIDTH(W)) bus ();

    assign bus.pc            = pc;
    assign bus.rom_ack       = rom_ack;
    assign bus.rom_data      = bus.rom_addr + 16'h0100;
    assign bus.redirect      = redirect;
    assign bus.redirect_addr = redirect_addr;
    assign bus.instr_ready   = instr_ready;

    fetch_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // program counter register driven by the fetch unit
    always @(posedge clk) begin
        if (bus.pc_load)     pc <= bus.pc_in;
        else if (bus.pc_inc) pc <= pc + 16'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // model: queue of fetched entries, whether a request is outstanding,
    // and whether that request was orphaned by a redirect
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] d;
    } ent_t;

    ent_t         mq[$];
    logic         m_req   = 1'b0;
    logic         m_stale = 1'b0;
    logic [W-1:0] m_saddr = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mq.delete();
                m_req   = 1'b0;
                m_stale = 1'b0;
                chk("m_rst_req", bus.rom_req, 1'b0);
                chk("m_rst_valid", bus.instr_valid, 1'b0);
            end else begin
                logic ack, inc, pop, nreq;
                int   sz;
                sz  = mq.size();
                ack = m_req & rom_ack;
                inc = ack & ~redirect & ~m_stale;
                pop = (sz != 0) & instr_ready & ~redirect;
                chk("m_rom_req", bus.rom_req, m_req);
                chk("m_valid", bus.instr_valid, sz != 0);
                if (sz != 0) begin
                    chk("m_instr_pc", bus.instr_pc, mq[0].a);
                    chk("m_instr", bus.instr, mq[0].d);
                end
                chk("m_pc_inc", bus.pc_inc, inc);
                chk("m_pc_load", bus.pc_load, redirect);
                if (redirect) chk("m_pc_in", bus.pc_in, redirect_addr);
                if (m_req)
                    chk("m_rom_addr", bus.rom_addr, m_stale ? m_saddr : pc);
                if (redirect)
                    nreq = m_req & ~ack;
                else if (m_req & ~ack)
                    nreq = 1'b1;
                else if (m_req & m_stale)
                    nreq = 1'b0;
                else if (m_req)
                    nreq = (sz - int'(pop) + 1) < D;
                else
                    nreq = sz < D;
                if (redirect) begin
                    mq.delete();
                end else begin
                    if (pop) void'(mq.pop_front());
                    if (inc) mq.push_back('{a: pc, d: pc + 16'h0100});
                end
                if (redirect && m_req && !ack) begin
                    if (!m_stale) m_saddr = pc;
                    m_stale = 1'b1;
                end else if (ack) begin
                    m_stale = 1'b0;
                end
                m_req = nreq;
            end
        end
    end

    initial begin
        reset         = 1'b1;
        rom_ack       = 1'b1;
        instr_ready   = 1'b1;
        redirect      = 1'b0;
        redirect_addr = '0;
        #1;
        chk("rst_req", bus.rom_req, 1'b0);
        chk("rst_valid", bus.instr_valid, 1'b0);
        chk("rst_pc_inc", bus.pc_inc, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        // streaming from pc=0
        cyc();
        chk("t1_req", bus.rom_req, 1'b1);
        chk("t1_addr0", bus.rom_addr, 16'h0000);
        chk("t1_inc", bus.pc_inc, 1'b1);
        chk("t1_nvalid", bus.instr_valid, 1'b0);
        cyc();
        chk("t1_valid", bus.instr_valid, 1'b1);
        chk("t1_ipc0", bus.instr_pc, 16'h0000);
        chk("t1_ins0", bus.instr, 16'h0100);
        chk("t1_addr1", bus.rom_addr, 16'h0001);
        chk("t1_pc1", pc, 16'h0001);
        cyc();
        chk("t1_ipc1", bus.instr_pc, 16'h0001);
        chk("t1_ins1", bus.instr, 16'h0101);
        repeat (3) cyc();
        chk("t1_addr5", bus.rom_addr, 16'h0005);
        chk("t1_ipc4", bus.instr_pc, 16'h0004);

        // redirect while waiting for ack at addr 5
        rom_ack = 1'b0;
        cyc();
        chk("t3_addr5", bus.rom_addr, 16'h0005);
        chk("t3_empty", bus.instr_valid, 1'b0);
        redirect      = 1'b1;
        redirect_addr = 16'h0040;
        #1;
        chk("t3_load", bus.pc_load, 1'b1);
        chk("t3_noinc", bus.pc_inc, 1'b0);
        cyc();
        redirect = 1'b0;
        chk("t3_flush_req", bus.rom_req, 1'b1);
        chk("t3_flush_addr", bus.rom_addr, 16'h0005);
        chk("t3_pc40", pc, 16'h0040);
        cyc();
        rom_ack = 1'b1;
        #1;
        chk("t3_drop_inc", bus.pc_inc, 1'b0);
        cyc();
        chk("t3_idle", bus.rom_req, 1'b0);
        chk("t3_nopush", bus.instr_valid, 1'b0);
        cyc();
        chk("t3_addr40", bus.rom_addr, 16'h0040);
        cyc();
        chk("t3_ipc40", bus.instr_pc, 16'h0040);
        chk("t3_ins40", bus.instr, 16'h0140);

        // decode stalls: FIFO fills to DEPTH then fetch stops
        instr_ready = 1'b0;
        cyc();
        chk("t2_stop", bus.rom_req, 1'b0);
        chk("t2_head", bus.instr_pc, 16'h0040);
        chk("t2_pc", pc, 16'h0042);
        cyc();
        chk("t2_still", bus.rom_req, 1'b0);
        chk("t2_noinc", bus.pc_inc, 1'b0);
        instr_ready = 1'b1;
        cyc();
        chk("t2_ipc41", bus.instr_pc, 16'h0041);
        chk("t2_ins41", bus.instr, 16'h0141);
        cyc();
        chk("t2_resume", bus.rom_req, 1'b1);
        chk("t2_addr42", bus.rom_addr, 16'h0042);
        cyc();
        chk("t4_head42", bus.instr_pc, 16'h0042);

        // redirect coincident with ack and pop
        redirect      = 1'b1;
        redirect_addr = 16'hFFFE;
        #1;
        chk("t4_noinc", bus.pc_inc, 1'b0);
        chk("t4_load", bus.pc_load, 1'b1);
        cyc();
        redirect = 1'b0;
        chk("t4_empty", bus.instr_valid, 1'b0);
        chk("t4_idle", bus.rom_req, 1'b0);
        cyc();
        chk("t5_addr", bus.rom_addr, 16'hFFFE);
        cyc();
        chk("t5_ipc0", bus.instr_pc, 16'hFFFE);
        cyc();
        chk("t5_ipc1", bus.instr_pc, 16'hFFFF);
        cyc();
        chk("t5_ipc2", bus.instr_pc, 16'h0000);
        chk("t5_ins2", bus.instr, 16'h0100);

        // asynchronous reset between edges
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("t6_req", bus.rom_req, 1'b0);
        chk("t6_valid", bus.instr_valid, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("t6_pc", pc, 16'h0002);
        cyc();
        chk("t6_restart", bus.rom_req, 1'b1);
        chk("t6_addr", bus.rom_addr, 16'h0002);
        chk("t6_empty", bus.instr_valid, 1'b0);

        // random ack/ready/redirect traffic, checked by the model
        for (int i = 0; i < 400; i++) begin
            cyc();
            rom_ack       = $urandom_range(0, 3) != 0;
            instr_ready   = $urandom_range(0, 3) != 0;
            redirect      = !redirect && ($urandom_range(0, 15) == 0);
            redirect_addr = 16'($urandom);
        end
        cyc();
        redirect = 1'b0;
        repeat (4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly downstream of the program counter. It drives the PC's inc/load/in controls, issues single-outstanding read requests to instruction ROM, and buffers returned instructions with their addresses in a small FIFO. The decode stage pulls instructions through a valid/ready handshake. A redirect input (jump taken) reloads the PC and flushes all fetched and in-flight instructions.

Parameters:
WIDTH, 16, instruction and address width; equals the PC width.
DEPTH, 2, instruction FIFO entries; must be at least 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
pc  input  WIDTH  current PC register output.
pc_inc  output  1  PC increment request; combinational.
pc_load  output  1  PC load request; combinational, equals redirect.
pc_in  output  WIDTH  PC load value; equals redirect_addr.
rom_req  output  1  ROM read request; registered.
rom_addr  output  WIDTH  ROM read address; registered (addr_q).
rom_ack  input  1  ROM accepts the request and returns data in the same cycle.
rom_data  input  WIDTH  instruction word, valid when rom_ack=1.
redirect  input  1  jump taken; single-cycle pulse.
redirect_addr  input  WIDTH  jump target.
instr_valid  output  1  FIFO head is valid.
instr_ready  input  1  decode accepts the FIFO head.
instr  output  WIDTH  FIFO head instruction.
instr_pc  output  WIDTH  address of the FIFO head instruction.

Behaviour:
- Reset (async, any time, including mid-request) sets:
  - state=IDLE, count=0, addr_q=0, rom_req=0, instr_valid=0.
  - Pending ROM data is dropped.
- State machine:
  - IDLE: rom_req=0. If no redirect and count<DEPTH, then addr_q<=pc and go to REQ. A redirect in IDLE keeps the block in IDLE.
  - REQ: rom_req=1, rom_addr=addr_q, held stable until ack.
    - ack with no redirect: push {addr_q, rom_data} and assert pc_inc.
    - After the push, stay in REQ with addr_q<=addr_q+1 if (count+1-pop)<DEPTH. Otherwise go to IDLE.
    - Redirect with ack in the same cycle: discard the data, no pc_inc, go to IDLE.
    - Redirect without ack: go to FLUSH.
  - FLUSH: rom_req=1 with the old addr_q. On ack, discard the data and go to IDLE. A further redirect stays in FLUSH.
- Invariant: in REQ with no redirect pending, pc==addr_q.
- Arithmetic: addr_q+1 wraps modulo 2^WIDTH (0xFFFF becomes 0x0000), matching the PC's increment.
- Redirect priority:
  - pc_load=1 in the redirect cycle; pc_inc forced to 0.
  - FIFO count<=0 at the next edge. A same-cycle pop or push is ignored.
- FIFO behaviour:
  - pop = instr_valid & instr_ready & ~redirect.
  - Simultaneous push and pop leaves count unchanged.
  - No push ever occurs when full: a request only starts or continues with guaranteed room, and at most one request is outstanding.
  - instr_valid = (count!=0).
  - instr and instr_pc show the head entry.
  - Data is first-word-fall-through; a pushed entry is visible the cycle after the push.
- Throughput: one instruction per cycle when rom_ack=1 continuously and decode pops every cycle.

Test Plan:
1. Reset released, pc=0, rom_ack=1, instr_ready=1, rom_data=addr+0x100 -> rom_req=1 from cycle 1 with addresses 0,1,2,…; pc_inc=1 each cycle; instr_valid from cycle 2 with instr_pc=0, instr=0x0100, then one new entry per cycle.
2. instr_ready=0, rom_ack=1 -> exactly DEPTH=2 pushes (addresses 0,1); rom_req=0 in the cycle after the second ack; pc=2. Raising instr_ready -> 0x0100 and 0x0101 pop in order; fetching resumes at address 2.
3. In REQ at addr 5, rom_ack=0, then redirect=1 with redirect_addr=0x0040 -> pc_load=1 and FIFO empty next cycle; state FLUSH with rom_addr=5. Later ack -> data not pushed. Next request uses rom_addr=0x0040 and the first entry has instr_pc=0x0040.
4. Redirect coincident with an ack at addr 7 and a pop -> no push, pc_inc=0, count=0 next cycle, next fetch from redirect_addr.
5. pc=0xFFFE, streaming -> instr_pc sequence 0xFFFE, 0xFFFF, 0x0000.
6. reset asserted asynchronously mid-REQ, between clock edges -> rom_req and instr_valid drop immediately. After release, fetching restarts from the current pc with an empty FIFO.
